// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory write-buffer slice.
package dmem_pkg;

    localparam int WORD_W      = 64;
    localparam int D_ADDR_BITS = 6;

    typedef struct packed {
        logic [D_ADDR_BITS-1:0] addr;
        logic [WORD_W-1:0]      data;
    } wbuf_entry_t;

endpackage

// File: rtl/dmem_wbuf_fifo.sv
// Circular store buffer: push/pop, occupancy count and youngest-match lookup.
module dmem_wbuf_fifo
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ADDR_W-1:0]        push_addr,
    input  logic [WORD_W-1:0]        push_data,
    input  logic                     pop,
    output logic [ADDR_W-1:0]        head_addr,
    output logic [WORD_W-1:0]        head_data,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [ADDR_W-1:0]        lookup_addr,
    output logic                     hit,
    output logic [WORD_W-1:0]        hit_data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [WORD_W-1:0] data_q [DEPTH];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + 1'b1;
        if (pop)  head_d = head_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= push_addr;
            data_q[tail_q] <= push_data;
        end
    end

    // Walk from oldest to youngest so the last valid match wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (addr_q[head_q + PW'(i)] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = data_q[head_q + PW'(i)];
            end
        end
    end

    assign head_addr = addr_q[head_q];
    assign head_data = data_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/dmem_wbuf.sv
// Data-memory slave: posted core stores drain into the array, loader shares the write port,
// loads are answered combinationally with forwarding from the store buffer.
module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int d_addr_bits = 6,
    parameter int depth       = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     d_mem_we,
    input  logic                     d_mem_re,
    input  logic [d_addr_bits-1:0]   d_mem_addr,
    inout  wire  [WORD_W-1:0]        d_mem_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [d_addr_bits-1:0]   ld_addr,
    input  logic [WORD_W-1:0]        ld_data,
    output logic [$clog2(depth):0]   buf_count,
    output logic                     buf_full,
    output logic                     buf_empty
);

    localparam int CW = $clog2(depth) + 1;
    localparam logic [CW-1:0] READY_LIM = CW'(depth - 1);
    localparam logic [CW-1:0] FULL_LVL  = CW'(depth);

    logic [WORD_W-1:0]      mem_q [2**d_addr_bits];
    logic [d_addr_bits-1:0] head_addr;
    logic [WORD_W-1:0]      head_data;
    logic [CW-1:0]          count;
    logic                   hit;
    logic [WORD_W-1:0]      hit_data;
    logic                   ld_xfer;
    logic                   drain;
    logic                   wr_en;
    logic [d_addr_bits-1:0] wr_addr;
    logic [WORD_W-1:0]      wr_data;
    logic [WORD_W-1:0]      rd_data;
    logic                   drive_bus;

    dmem_wbuf_fifo #(
        .ADDR_W (d_addr_bits),
        .DEPTH  (depth)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst_n),
        .push        (d_mem_we),
        .push_addr   (d_mem_addr),
        .push_data   (d_mem_data),
        .pop         (drain),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .count       (count),
        .lookup_addr (d_mem_addr),
        .hit         (hit),
        .hit_data    (hit_data)
    );

    // Holding the loader off at depth-1 forces a drain whenever a push could overflow.
    assign ld_ready = (count < READY_LIM);
    assign ld_xfer  = ld_valid && ld_ready;
    assign drain    = !ld_xfer && (count != '0);

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (ld_xfer) begin
            wr_en   = 1'b1;
            wr_addr = ld_addr;
            wr_data = ld_data;
        end else if (drain) begin
            wr_en   = 1'b1;
            wr_addr = head_addr;
            wr_data = head_data;
        end
    end

    // Reset gates the write so an edge under reset never commits a half-drained entry.
    always_ff @(posedge clk) begin
        if (wr_en && !rst_n) mem_q[wr_addr] <= wr_data;
    end

    assign rd_data    = hit ? hit_data : mem_q[d_mem_addr];
    assign drive_bus  = d_mem_re && !d_mem_we;
    assign d_mem_data = drive_bus ? rd_data : 'z;

    assign buf_count = count;
    assign buf_full  = (count == FULL_LVL);
    assign buf_empty = (count == '0);

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf with a queue-based reference model checked every cycle.
module tb_dmem_wbuf;

    localparam int AW    = 6;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0, re = 1'b0, ld_valid = 1'b0;
    logic [5:0]  addr = '0, ld_addr = '0;
    logic [63:0] wdata = '0, ld_data = '0;
    logic        ld_ready, buf_full, buf_empty;
    logic [2:0]  buf_count;
    wire  [63:0] bus;

    int errors = 0;
    int checks = 0;

    assign bus = we ? wdata : 'z;
    pullup pu_bus (bus);

    always #5 clk = ~clk;

    dmem_wbuf #(.d_addr_bits(AW), .depth(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst),
        .d_mem_we   (we),
        .d_mem_re   (re),
        .d_mem_addr (addr),
        .d_mem_data (bus),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .buf_count  (buf_count),
        .buf_full   (buf_full),
        .buf_empty  (buf_empty)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending stores as a queue, array as a plain memory.
    typedef struct {
        logic [5:0]  a;
        logic [63:0] d;
    } ent_t;

    ent_t        q[$];
    logic [63:0] m_mem   [64];
    bit          m_known [64];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
        end else begin
            if (ld_valid && q.size() < DEPTH - 1) begin
                m_mem[ld_addr]   <= ld_data;
                m_known[ld_addr] <= 1'b1;
            end else if (q.size() > 0) begin
                m_mem[q[0].a]   <= q[0].d;
                m_known[q[0].a] <= 1'b1;
                void'(q.pop_front());
            end
            if (we) q.push_back('{addr, wdata});
        end
    end

    bit          found_v;
    logic [63:0] exp_v;

    always @(negedge clk) begin
        check("count", {61'd0, buf_count}, 64'(q.size()));
        check("empty", {63'd0, buf_empty}, {63'd0, q.size() == 0});
        check("full",  {63'd0, buf_full},  {63'd0, q.size() == DEPTH});
        check("ready", {63'd0, ld_ready},  {63'd0, q.size() < DEPTH - 1});
        if (re && !we) begin
            found_v = 1'b0;
            exp_v   = '0;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!found_v && q[i].a == addr) begin
                    exp_v   = q[i].d;
                    found_v = 1'b1;
                end
            end
            if (!found_v && m_known[addr]) begin
                exp_v   = m_mem[addr];
                found_v = 1'b1;
            end
            if (found_v) check("load", bus, exp_v);
        end else if (we) begin
            check("bus_core", bus, wdata);
        end else begin
            check("bus_z", bus, '1);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc();
        cyc();
        #1;
        check("rst_count", {61'd0, buf_count}, 64'd0);
        check("rst_empty", {63'd0, buf_empty}, 64'd1);
        check("rst_full",  {63'd0, buf_full},  64'd0);
        check("rst_ready", {63'd0, ld_ready},  64'd1);
        check("rst_bus",   bus, '1);
        rst = 1'b0;
        cyc();

        // Loader fills the array with addr*3 while the core is idle.
        for (int a = 0; a < 64; a++) begin
            ld_valid = 1'b1;
            ld_addr  = 6'(a);
            ld_data  = 64'(a * 3);
            #1;
            check("ld_ready_idle", {63'd0, ld_ready}, 64'd1);
            cyc();
        end
        ld_valid = 1'b0;
        for (int a = 0; a < 64; a++) begin
            re   = 1'b1;
            addr = 6'(a);
            #1;
            check("ld_readback", bus, 64'(a * 3));
            cyc();
        end
        re = 1'b0;

        // Store then forward next cycle, then read back from the array.
        we = 1'b1; addr = 6'd5; wdata = 64'hDEADBEEF_00000001;
        cyc();
        we = 1'b0; re = 1'b1;
        #1;
        check("fwd5", bus, 64'hDEADBEEF_00000001);
        check("fwd5_count", {61'd0, buf_count}, 64'd1);
        cyc();
        re = 1'b0;
        cyc();
        re = 1'b1;
        #1;
        check("arr5", bus, 64'hDEADBEEF_00000001);
        check("arr5_count", {61'd0, buf_count}, 64'd0);
        cyc();
        re = 1'b0;

        // Loader holds the write port; two stores to addr 3, youngest must win.
        ld_valid = 1'b1; ld_addr = 6'd40; ld_data = 64'h4000;
        we = 1'b1; addr = 6'd3; wdata = 64'h11;
        cyc();
        wdata = 64'h22;
        cyc();
        we = 1'b0; re = 1'b1;
        #1;
        check("young3", bus, 64'h22);
        check("young3_count", {61'd0, buf_count}, 64'd2);
        cyc();
        ld_valid = 1'b0; re = 1'b0;
        cyc();
        cyc();
        re = 1'b1;
        #1;
        check("arr3", bus, 64'h22);
        check("arr3_count", {61'd0, buf_count}, 64'd0);
        cyc();
        re = 1'b0;

        // Back-to-back stores with the loader always requesting.
        ld_valid = 1'b1; ld_addr = 6'd41; ld_data = 64'h4100;
        for (int i = 0; i < 4; i++) begin
            we    = 1'b1;
            addr  = 6'(10 + i);
            wdata = 64'(32'hA0 + i);
            #1;
            check("full_ready", {63'd0, ld_ready}, (i < 3) ? 64'd1 : 64'd0);
            cyc();
        end
        we = 1'b0;
        #1;
        check("full_count", {61'd0, buf_count}, 64'd3);
        check("full_ready_after", {63'd0, ld_ready}, 64'd0);
        ld_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        for (int i = 0; i < 4; i++) begin
            re   = 1'b1;
            addr = 6'(10 + i);
            #1;
            check("full_arr", bus, 64'(32'hA0 + i));
            cyc();
        end
        re = 1'b0;

        // Three stores buffered behind the loader, then reset discards them.
        ld_valid = 1'b1; ld_addr = 6'd50; ld_data = 64'h5000;
        for (int i = 0; i < 3; i++) begin
            we    = 1'b1;
            addr  = 6'(20 + i);
            wdata = 64'(32'h900 + i);
            cyc();
        end
        we = 1'b0;
        #1;
        check("pre_rst_count", {61'd0, buf_count}, 64'd3);
        rst = 1'b1;
        #1;
        check("mid_rst_count", {61'd0, buf_count}, 64'd0);
        check("mid_rst_ready", {63'd0, ld_ready},  64'd1);
        check("mid_rst_empty", {63'd0, buf_empty}, 64'd1);
        check("mid_rst_bus",   bus, '1);
        cyc();
        rst = 1'b0; ld_valid = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            re   = 1'b1;
            addr = 6'(20 + i);
            #1;
            check("stale", bus, 64'((20 + i) * 3));
            cyc();
        end
        re = 1'b0;

        // Bus ownership: both strobes -> core owns the bus; idle -> released; load -> driven.
        we = 1'b1; re = 1'b1; addr = 6'd7; wdata = 64'h12345678_9ABCDEF0;
        #1;
        check("own_we_re", bus, 64'h12345678_9ABCDEF0);
        cyc();
        we = 1'b0; re = 1'b0;
        #1;
        check("own_idle", bus, '1);
        re = 1'b1;
        #1;
        check("own_load", bus, 64'h12345678_9ABCDEF0);
        cyc();
        re = 1'b0;
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_wbuf.md
# dmem_wbuf

Data-memory slave that sits directly downstream of the core's data-memory port and owns the shared 64-bit bidirectional data bus. Core stores are posted into a small write buffer and drained into a word-addressed storage array one per cycle. A program-loader port shares the array's single write port. Core loads are answered combinationally in the same cycle, with store-to-load forwarding from the buffer.

## Interface
- `d_addr_bits`, 6: word-address width; the array holds 2^d_addr_bits 64-bit words.
- `depth`, 4: write-buffer entries; must be a power of two, ≥2.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-high reset (asserted = 1); the name is kept for port consistency with the core.
- `d_mem_we` input 1: core store strobe.
- `d_mem_re` input 1: core load strobe.
- `d_mem_addr` input d_addr_bits: core word address.
- `d_mem_data` inout 64: driven by the core on stores; driven by this block on loads.
- `ld_valid` input 1: loader write request.
- `ld_ready` output 1: loader write accepted this cycle when both `ld_valid` and `ld_ready` are high.
- `ld_addr` input d_addr_bits: loader word address.
- `ld_data` input 64: loader write data.
- `buf_count` output $clog2(depth)+1: occupied buffer entries.
- `buf_full` output 1: `buf_count == depth`.
- `buf_empty` output 1: `buf_count == 0`.

## Operation
- **Buffer**
  - Circular FIFO of {addr, data} entries with head/tail pointers; pointers wrap modulo depth.
  - Push: any cycle with `d_mem_we=1`; captures `d_mem_addr` and the bus value.
- **Array write port**, one write per cycle, priority:
  1. Loader transfer, when `ld_valid && ld_ready`.
  2. Otherwise drain: if the buffer is non-empty, write the head entry to the array and pop it.
- **`ld_ready`**
  - `ld_ready = (buf_count < depth-1)`, combinational.
  - Guarantees a drain whenever the buffer is at depth-1 or full, so a core store is never dropped. The core has no stall input.
- **Simultaneous push and pop:** count unchanged. Push into a full buffer always coincides with a pop.
- **Load**
  - When `d_mem_re=1` and `d_mem_we=0`, the block drives `d_mem_data`:
    - the youngest buffer entry whose addr matches `d_mem_addr`, if any;
    - else `array[d_mem_addr]`.
  - Otherwise `d_mem_data` is high-Z.
  - `we` has priority when both strobes are high.
- **Ordering**
  - Loader writes bypass the buffer.
  - If the loader and the core target the same address while that address is buffered, the buffered core value wins once drained. Mixing the two on one address is unsupported; the loader is used while the core is held in reset.
- **Reset**
  - Pointers and count are cleared, and pending buffered stores are discarded.
  - Array contents are not reset.

## Timing
- Reset values:
  - `buf_count=0`, `buf_empty=1`, `buf_full=0`, `ld_ready=1`.
  - `d_mem_data` high-Z, since `re` is ignored only through the combinational rule.
- Store: captured at the edge where `we=1`. It is forwardable to a load in the next cycle. It reaches the array no earlier than the following edge.
- Load latency: 0 cycles (combinational from `addr`/`re`).
- Drain: the head is written on every edge with a non-empty buffer and no loader transfer.
- Reset asserted mid-drain: takes effect immediately (async). No partial array write occurs on that edge.
- `buf_full`/`buf_empty`/`buf_count` are registered-state derived and update after the edge.

## Structure
- Package `dmem_pkg`:
  - `WORD_W=64`.
  - Entry struct typedef `wbuf_entry_t` {addr, data}, parameterised through a localparam default of `d_addr_bits=6`.
- Sub-module `dmem_wbuf_fifo`:
  - circular buffer;
  - push/pop;
  - count;
  - youngest-match address lookup returning {hit, data}.
- The top level holds the array, write-port arbitration, `ld_ready`, and the tristate driver.

## Test plan
- **Reset:** assert `rst_n=1` mid-run with 3 entries buffered → `buf_count=0`, `ld_ready=1`, bus Z. The stale array value at those addresses is still returned after release.
- **Store/forward:** store 0xDEADBEEF_00000001 to addr 5, then load addr 5 next cycle → bus reads 0xDEADBEEF_00000001 from the buffer. Two cycles later the array holds the same value.
- **Youngest match:** loader holds the drain while the core stores addr 3 = 0x11 then addr 3 = 0x22; load addr 3 → 0x22. After drain completes, `array[3]=0x22`.
- **Full boundary:** `ld_valid` held high while the core issues 4 back-to-back stores → `ld_ready` drops when `buf_count` reaches 3. Count never exceeds 4, and all 4 stores land in the array in order.
- **Loader:** core idle, 64 loader writes of value addr*3 → `ld_ready` constantly 1. Loads of addr 0..63 return addr*3.
- **Bus ownership:** `re=we=1` → block leaves the bus Z. `re=0` → Z. `re=1,we=0` → driven.
